// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first through one full-adder cell and a carry flop.
// Latency: start accepted at edge k -> done pulse and valid sum/cout in the cycle after edge k+WIDTH.
// Backpressure: none; start is ignored while busy. Optional ovf output under macro SERIAL_ADDER_OVF_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             c;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             s_bit;
    logic             c_nxt;

    // The single full-adder cell shared by every bit position.
    always_comb begin
        s_bit = a_sr[0] ^ b_sr[0] ^ c;
        c_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);

    // Control FSM and datapath; sum/cout (and ovf) only move on the last shift edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            c     <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            r_sr  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        c     <= cin;
                        cnt   <= '0;
                        state <= S_SHIFT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    r_sr <= {s_bit, r_sr[WIDTH-1:1]};
                    c    <= c_nxt;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) begin
                        // Bypass the result register so the full word lands on sum in one step.
                        sum   <= {s_bit, r_sr[WIDTH-1:1]};
                        cout  <= c_nxt;
`ifdef SERIAL_ADDER_OVF_EN
                        // c is the carry into the MSB at this point.
                        ovf   <= c ^ c_nxt;
`endif
                        state <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8) against an arithmetic reference model.
// Covers reset, directed and random sums, ignored mid-flight starts, held start and mid-op reset.
// Outputs are sampled on the falling edge; inputs driven on the falling edge.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_sum;
    logic         prev_cout;
    logic         prev_ovf;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition; signed overflow from carry into vs out of the MSB.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        int full;
        int low;
        logic co;
        logic ci_msb;
        full   = int'(ma) + int'(mb) + int'(mc);
        low    = int'(ma % (1 << (W - 1))) + int'(mb % (1 << (W - 1))) + int'(mc);
        co     = (full >= (1 << W));
        ci_msb = (low >= (1 << (W - 1)));
        model  = {ci_msb ^ co, co, W'(full)};
    endfunction

    task automatic check_result(input string tag, input logic [W+1:0] e);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
        check({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
        prev_sum  = e[W-1:0];
        prev_cout = e[W];
        prev_ovf  = e[W+1];
    endtask

    task automatic check_held(input string tag);
        check({tag, "_held_sum"}, 32'(sum), 32'(prev_sum));
        check({tag, "_held_cout"}, 32'(cout), 32'(prev_cout));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "_held_ovf"}, 32'(ovf), 32'(prev_ovf));
`endif
    endtask

    // One operation; glitch_at re-pulses start in that busy cycle, rst_at aborts with reset there.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic ocin, input int glitch_at, input int rst_at);
        logic [W+1:0] e;
        e = model(oa, ob, ocin);
        @(negedge clk);
        a = oa; b = ob; cin = ocin; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            start = 1'b0;
            check({tag, "_busy_cyc"}, 32'(busy), 32'd1);
            check({tag, "_nodone_cyc"}, 32'(done), 32'd0);
            check_held(tag);
            if (i == glitch_at) begin
                start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b1;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                check({tag, "_rst_done"}, 32'(done), 32'd0);
                check({tag, "_rst_sum"}, 32'(sum), 32'd0);
                check({tag, "_rst_cout"}, 32'(cout), 32'd0);
                prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
                for (int j = 0; j < W + 3; j++) begin
                    @(negedge clk);
                    check({tag, "_rst_nodone"}, 32'(done), 32'd0);
                end
                return;
            end
        end
        @(negedge clk);
        start = 1'b0;
        check_result(tag, e);
        @(negedge clk);
        check({tag, "_pulse_end"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    logic [W-1:0] ha [4];
    logic [W-1:0] hb [4];
    logic         hc [4];

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        prev_sum = '0; prev_cout = 1'b0; prev_ovf = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        @(negedge clk);
        check("idle_done", 32'(done), 32'd0);

        run_op("d_0f_01", 8'h0F, 8'h01, 1'b0, -1, -1);
        run_op("d_ff_01", 8'hFF, 8'h01, 1'b0, -1, -1);
        run_op("d_ff_ff_c", 8'hFF, 8'hFF, 1'b1, -1, -1);
        run_op("glitch", 8'h0F, 8'h01, 1'b0, 2, -1);
        run_op("glitch_last", 8'hA5, 8'h3C, 1'b1, W - 1, -1);
        run_op("midrst", 8'h55, 8'h66, 1'b1, -1, 3);
        run_op("d_12_34", 8'h12, 8'h34, 1'b0, -1, -1);
`ifdef SERIAL_ADDER_OVF_EN
        run_op("ovf_7f_01", 8'h7F, 8'h01, 1'b0, -1, -1);
        run_op("ovf_80_80", 8'h80, 8'h80, 1'b0, -1, -1);
        run_op("ovf_40_10", 8'h40, 8'h10, 1'b0, -1, -1);
`endif

        // start held high: back-to-back results every W+1 cycles.
        for (int j = 0; j < 4; j++) begin
            ha[j] = W'($urandom); hb[j] = W'($urandom); hc[j] = 1'($urandom);
        end
        @(negedge clk);
        a = ha[0]; b = hb[0]; cin = hc[0]; start = 1'b1;
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < W; i++) begin
                @(negedge clk);
                if (i == 0) begin
                    if (j < 3) begin
                        a = ha[j+1]; b = hb[j+1]; cin = hc[j+1];
                    end else begin
                        start = 1'b0;
                    end
                end
                check("held_busy", 32'(busy), 32'd1);
                check("held_nodone", 32'(done), 32'd0);
                check_held("held");
            end
            @(negedge clk);
            check_result("held_res", model(ha[j], hb[j], hc[j]));
        end
        @(negedge clk);
        check("held_idle_done", 32'(done), 32'd0);
        check("held_idle_busy", 32'(busy), 32'd0);

        // Random operations, some with an ignored start during busy.
        for (int n = 0; n < 16; n++) begin
            int g;
            g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1;
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), g, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
